// File: rtl/ccff_chain_loader_if.sv
// ccff_chain_loader_if: bitstream word stream into the chain loader.
// Plain valid/ready; a word moves when both are high at a clock edge.
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (
    output cfg_data,
    output cfg_valid,
    input  cfg_ready
  );

  modport slave (
    input  cfg_data,
    input  cfg_valid,
    output cfg_ready
  );
endinterface

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serial programmer for the ccff configuration chain.
// Shifts the bitstream into ccff_head, then optionally rotates and CRC-checks it.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              verify_en,
  ccff_chain_loader_if.slave cfg,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              crc_ok
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int BW = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    VERIFY,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic              verify_q;
  logic [CW-1:0]     bit_cnt;
  logic [CW-1:0]     load_rem;
  logic [BW-1:0]     buf_cnt;
  logic [BW-1:0]     take;
  logic [WORD_W-1:0] word_q;
  logic              head_q;
  logic              shift_q;
  logic [7:0]        write_crc;
  logic [7:0]        read_crc;
  logic              crc_ok_q;
  logic              crc_res;
  logic              accept;
  logic              last_shift;

  function automatic logic [7:0] crc8(
    input logic [7:0] c,
    input logic       b
  );
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  // the final word may carry more bits than the chain still needs
  assign take = (int'(load_rem) >= WORD_W) ?
                BW'(WORD_W) : BW'(load_rem);

  assign accept     = cfg.cfg_ready & cfg.cfg_valid;
  assign last_shift = (state == LOAD) & shift_q &
                      (bit_cnt == CW'(1));
  assign crc_res    = verify_q ? (read_crc == write_crc) : 1'b1;

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    busy          = 1'b0;
    done          = 1'b0;
    ccff_shift_en = 1'b0;
    ccff_head     = head_q;
    crc_ok        = crc_ok_q;
    cfg.cfg_ready = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        busy          = 1'b1;
        ccff_shift_en = shift_q;
        cfg.cfg_ready = (load_rem != '0) &&
                        (buf_cnt == '0);
        if (last_shift)
          state_nxt = verify_q ? VERIFY : DONE;
      end
      VERIFY: begin
        busy          = 1'b1;
        ccff_shift_en = 1'b1;
        ccff_head     = ccff_tail;
        if (bit_cnt == CW'(1)) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        crc_ok    = crc_res;
        state_nxt = IDLE;
      end
    endcase
  end

  // head_q is the bit on ccff_head; word_q holds the bits behind it
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      verify_q  <= 1'b0;
      bit_cnt   <= '0;
      load_rem  <= '0;
      buf_cnt   <= '0;
      word_q    <= '0;
      head_q    <= 1'b0;
      shift_q   <= 1'b0;
      write_crc <= '0;
      read_crc  <= '0;
      crc_ok_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            verify_q  <= verify_en;
            bit_cnt   <= CW'(CHAIN_LEN);
            load_rem  <= CW'(CHAIN_LEN);
            buf_cnt   <= '0;
            shift_q   <= 1'b0;
            write_crc <= '0;
            read_crc  <= '0;
            crc_ok_q  <= 1'b0;
          end
        end
        LOAD: begin
          if (shift_q) begin
            write_crc <= crc8(write_crc, head_q);
            bit_cnt   <= bit_cnt - CW'(1);
          end
          if (last_shift) bit_cnt <= CW'(CHAIN_LEN);
          if (accept) begin
            head_q   <= cfg.cfg_data[WORD_W-1];
            word_q   <= cfg.cfg_data << 1;
            buf_cnt  <= take - BW'(1);
            load_rem <= load_rem - CW'(take);
            shift_q  <= 1'b1;
          end else if (buf_cnt != '0) begin
            head_q  <= word_q[WORD_W-1];
            word_q  <= word_q << 1;
            buf_cnt <= buf_cnt - BW'(1);
            shift_q <= 1'b1;
          end else begin
            shift_q <= 1'b0;
          end
        end
        VERIFY: begin
          read_crc <= crc8(read_crc, ccff_tail);
          bit_cnt  <= bit_cnt - CW'(1);
        end
        DONE: begin
          crc_ok_q <= crc_res;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: directed vectors against a behavioural chain model.
// Two instances: a 10-flop chain (most cases) and a 16-flop chain.
module tb_ccff_chain_loader;

  localparam int LA = 10;
  localparam int LB = 16;
  localparam int W  = 8;

  logic prog_clk = 1'b0;
  logic pReset   = 1'b1;
  always #5 prog_clk = ~prog_clk;

  logic start_a = 1'b0, ven_a = 1'b0, fault = 1'b0;
  logic head_a, sh_a, tail_a, busy_a, done_a, ok_a;
  logic start_b = 1'b0, ven_b = 1'b0;
  logic head_b, sh_b, tail_b, busy_b, done_b, ok_b;

  logic [LA-1:0] chain_a = '0;
  logic [LB-1:0] chain_b = '0;

  ccff_chain_loader_if #(.WORD_W(W)) cfg_a ();
  ccff_chain_loader_if #(.WORD_W(W)) cfg_b ();

  ccff_chain_loader #(.CHAIN_LEN(LA), .WORD_W(W)) dut_a (
    .prog_clk      (prog_clk),
    .pReset        (pReset),
    .start         (start_a),
    .verify_en     (ven_a),
    .cfg           (cfg_a),
    .ccff_head     (head_a),
    .ccff_shift_en (sh_a),
    .ccff_tail     (tail_a),
    .busy          (busy_a),
    .done          (done_a),
    .crc_ok        (ok_a)
  );

  ccff_chain_loader #(.CHAIN_LEN(LB), .WORD_W(W)) dut_b (
    .prog_clk      (prog_clk),
    .pReset        (pReset),
    .start         (start_b),
    .verify_en     (ven_b),
    .cfg           (cfg_b),
    .ccff_head     (head_b),
    .ccff_shift_en (sh_b),
    .ccff_tail     (tail_b),
    .busy          (busy_b),
    .done          (done_b),
    .crc_ok        (ok_b)
  );

  // chain models: shift toward the tail, first bit ends at the tail end
  assign tail_a = chain_a[LA-1] ^ fault;
  assign tail_b = chain_b[LB-1];

  always @(posedge prog_clk) begin
    if (sh_a) chain_a <= {chain_a[LA-2:0], head_a};
    if (sh_b) chain_b <= {chain_b[LB-2:0], head_b};
  end

  typedef struct {
    logic          ve;
    logic [7:0]    w0;
    logic [7:0]    w1;
    int            stall;
    int            fault_at;
    logic          poke;
    logic [LA-1:0] chain;
    int            done_cyc;
    logic          ok;
    int            shifts;
  } vec_t;

  vec_t tbl[6];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int   c, wi, sctr, shifts, gaps, dcyc, extra;
    logic acc, ok_d, last_hd, hold_ok, held;
    c = 0; wi = 0; sctr = 0; shifts = 0; gaps = 0;
    dcyc = -1; extra = 0; ok_d = 1'b0;
    last_hd = 1'b0; hold_ok = 1'b1; held = 1'b1;
    @(negedge prog_clk);
    while (c < 200 && dcyc < 0) begin
      if (sh_a) begin
        shifts++;
        last_hd = head_a;
      end else if (shifts > 0 && shifts < LA && busy_a) begin
        gaps++;
        if (head_a !== last_hd) hold_ok = 1'b0;
      end
      fault = sh_a && v.fault_at > 0 &&
              shifts == LA + v.fault_at;
      if (done_a) begin
        dcyc = c;
        ok_d = ok_a;
      end
      start_a = (c == 0) ||
                (v.poke && (c == 5 || c == 15 || c == 22));
      ven_a = (c == 0) ? v.ve : 1'b0;
      cfg_a.cfg_valid = (wi < 2) &&
                        !(wi == 1 && sctr < v.stall);
      cfg_a.cfg_data = (wi == 0) ? v.w0 : v.w1;
      if (wi == 1 && cfg_a.cfg_ready && !cfg_a.cfg_valid)
        sctr++;
      acc = cfg_a.cfg_valid && cfg_a.cfg_ready;
      @(posedge prog_clk);
      if (acc) wi++;
      @(negedge prog_clk);
      c++;
    end
    fault = 1'b0;
    start_a = 1'b0;
    cfg_a.cfg_valid = 1'b0;
    chk($sformatf("v%0d done_cyc", id), dcyc, v.done_cyc);
    chk($sformatf("v%0d crc_ok", id), ok_d, v.ok);
    chk($sformatf("v%0d shifts", id), shifts, v.shifts);
    chk($sformatf("v%0d stall_gaps", id), gaps, v.stall);
    chk($sformatf("v%0d head_hold", id), hold_ok, 1);
    chk($sformatf("v%0d chain", id), chain_a, v.chain);
    chk($sformatf("v%0d busy_after", id), busy_a, 0);
    for (int k = 0; k < 4; k++) begin
      if (done_a) extra++;
      if (ok_a !== v.ok) held = 1'b0;
      @(negedge prog_clk);
    end
    chk($sformatf("v%0d extra_done", id), extra, 0);
    chk($sformatf("v%0d crc_ok_held", id), held, 1);
  endtask

  initial begin
    int c, wi, shifts, first, last, dcyc;
    logic ok_d, acc;

    tbl[0] = '{1'b1, 8'hA5, 8'hC0, 0, 0, 1'b0,
               10'b1010010111, 22, 1'b1, 20};
    tbl[1] = '{1'b1, 8'hA5, 8'hC0, 0, 4, 1'b0,
               10'b1011010111, 22, 1'b0, 20};
    tbl[2] = '{1'b1, 8'hA5, 8'hC0, 5, 0, 1'b0,
               10'b1010010111, 27, 1'b1, 20};
    tbl[3] = '{1'b0, 8'h5A, 8'h80, 0, 0, 1'b0,
               10'b0101101010, 12, 1'b1, 10};
    tbl[4] = '{1'b1, 8'h3C, 8'h7F, 0, 0, 1'b0,
               10'b0011110001, 22, 1'b1, 20};
    tbl[5] = '{1'b1, 8'hA5, 8'hC0, 0, 0, 1'b1,
               10'b1010010111, 22, 1'b1, 20};

    cfg_a.cfg_valid = 1'b0;
    cfg_a.cfg_data  = '0;
    cfg_b.cfg_valid = 1'b0;
    cfg_b.cfg_data  = '0;

    repeat (3) @(negedge prog_clk);
    chk("reset outs a",
        {head_a, sh_a, busy_a, done_a, ok_a, cfg_a.cfg_ready}, 0);
    chk("reset outs b",
        {head_b, sh_b, busy_b, done_b, ok_b, cfg_b.cfg_ready}, 0);
    pReset = 1'b0;
    @(negedge prog_clk);
    chk("idle after reset", {busy_a, busy_b, sh_a, sh_b}, 0);

    for (int i = 0; i < 6; i++) run_vec(tbl[i], i);

    // reset in the 5th LOAD cycle (cycle 5, mid-shift)
    start_a = 1'b1;
    ven_a   = 1'b1;
    @(negedge prog_clk);
    start_a = 1'b0;
    ven_a   = 1'b0;
    cfg_a.cfg_valid = 1'b1;
    cfg_a.cfg_data  = 8'hA5;
    @(negedge prog_clk);
    cfg_a.cfg_valid = 1'b0;
    repeat (3) @(negedge prog_clk);
    chk("rst pre shift_en", sh_a, 1);
    pReset = 1'b1;
    #1;
    chk("rst async outs",
        {head_a, sh_a, busy_a, done_a, ok_a, cfg_a.cfg_ready}, 0);
    @(negedge prog_clk);
    pReset = 1'b0;
    run_vec(tbl[0], 6);

    // no-verify on the 16-flop chain
    @(negedge prog_clk);
    c = 0; wi = 0; shifts = 0; first = -1; last = -1;
    dcyc = -1; ok_d = 1'b0;
    while (c < 200 && dcyc < 0) begin
      if (sh_b) begin
        shifts++;
        if (first < 0) first = c;
        last = c;
      end
      if (done_b) begin
        dcyc = c;
        ok_d = ok_b;
      end
      start_b = (c == 0);
      ven_b = 1'b0;
      cfg_b.cfg_valid = (wi < 2);
      cfg_b.cfg_data = (wi == 0) ? 8'h12 : 8'h34;
      acc = cfg_b.cfg_valid && cfg_b.cfg_ready;
      @(posedge prog_clk);
      if (acc) wi++;
      @(negedge prog_clk);
      c++;
    end
    start_b = 1'b0;
    cfg_b.cfg_valid = 1'b0;
    chk("b first_shift", first, 2);
    chk("b last_shift", last, 17);
    chk("b shifts", shifts, 16);
    chk("b done_cyc", dcyc, 18);
    chk("b crc_ok", ok_d, 1);
    chk("b chain", chain_b, 16'h1234);
    chk("b busy_after", busy_b, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Configuration-chain programmer: the initiator end of the `ccff_head` → `ccff_tail` configuration flip-flop chain that threads through the logical tiles. It accepts the bitstream as words over a valid/ready stream and shifts it serially into `ccff_head`, producing a shift enable for the external gating of the chain clock. It can then optionally recirculate the chain once, so `ccff_tail` feeds back into `ccff_head`, and compare CRC-8 of the read-back bits against CRC-8 of the written bits. The block sits at fabric top level, between the bitstream source and the chain head/tail.

## Interface
- `CHAIN_LEN`, default 64: number of configuration flops in the chain (≥1).
- `WORD_W`, default 8: width of the input word (≥1).

- `prog_clk` in 1: programming clock; all state is on its rising edge.
- `pReset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request; honoured only in IDLE.
- `verify_en` in 1: sampled together with `start`; selects the readback pass.
- `cfg_data` in WORD_W: bitstream word, MSB shifted first.
- `cfg_valid` in 1: `cfg_data` is valid.
- `cfg_ready` out 1: word accepted when `cfg_valid & cfg_ready`.
- `ccff_head` out 1: serial data to the chain head.
- `ccff_shift_en` out 1: the chain advances on the `prog_clk` edge that ends a cycle in which this is 1.
- `ccff_tail` in 1: serial data from the chain tail.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle completion pulse.
- `crc_ok` out 1: result flag; valid while `done` is 1 and held until the next `start`.

## Operation
- States: IDLE, LOAD, VERIFY, DONE.
- **IDLE → LOAD**
  - Taken on `start`. The block latches `verify_en`, clears both CRCs, and loads the bit counter with CHAIN_LEN.
  - `start` outside IDLE is ignored.
- **LOAD**
  - A 1-word bit buffer holds the current word. `cfg_ready` = LOAD & words_remaining>0 & (buffer empty, or buffer holding its last bit that is being shifted this cycle). This gives zero bubbles between words.
  - Each cycle the buffer has a bit, the block asserts `ccff_shift_en`, drives the bit on `ccff_head`, decrements the bit counter, and updates write_crc.
  - Words accepted = ceil(CHAIN_LEN/WORD_W). Bits of the final word beyond CHAIN_LEN (its LSBs) are discarded and never shifted.
  - When no bit is available (`cfg_valid` low), `ccff_shift_en` is 0 and `ccff_head` holds its last value.
  - After the CHAIN_LEN-th shift: go to VERIFY if verify was latched, else DONE.
- **VERIFY**
  - Exactly CHAIN_LEN consecutive cycles with `ccff_shift_en`=1. `ccff_head` is driven combinationally from `ccff_tail`, which rotates the chain once and leaves its contents unchanged.
  - read_crc is updated from `ccff_tail` each cycle.
  - Then go to DONE.
- **DONE**
  - One cycle: `done`=1. `crc_ok` = (read_crc == write_crc) if verify was latched, else 1.
  - Then go to IDLE.
- **CRC-8** (poly 0x07, init 0x00, bit-serial, first bit first):
  - fb = crc[7] ^ bit
  - crc = {crc[6:0],1'b0} ^ (fb ? 8'h07 : 8'h00)
- Counters are sized $clog2(CHAIN_LEN+1); no wrap-around is permitted.

## Timing
- **Reset values:** all outputs are 0 (`cfg_ready`, `ccff_head`, `ccff_shift_en`, `busy`, `done`, `crc_ok`) and the state is IDLE.
  - Reset asserted mid-LOAD or mid-VERIFY drops `ccff_shift_en` immediately (asynchronously). Chain contents are then undefined and a full reload is required.
- `start` sampled at edge 0 → LOAD and `busy`=1 in cycle 1; `cfg_ready` can be 1 in cycle 1.
- A word accepted at the edge ending cycle n has its MSB on `ccff_head` with `ccff_shift_en`=1 in cycle n+1. `ccff_head` and `ccff_shift_en` are registered in LOAD.
- With `cfg_valid` held high, LOAD shifts CHAIN_LEN back-to-back cycles starting at cycle 2.
- VERIFY starts in the cycle immediately after the last LOAD shift, with no gap in `ccff_shift_en`.
- `done` follows the last shift cycle by one cycle. `busy` falls in the cycle after `done`.
- The earliest accepted new `start` is in the cycle after `done`.

## Test plan
- **Basic load + verify.** CHAIN_LEN=10, WORD_W=8; bench chain model; words 0xA5, 0xC0 with `cfg_valid` held; verify_en=1 → chain holds 1010010111, `ccff_shift_en` high for 20 consecutive cycles from cycle 2, `done` in cycle 22, `crc_ok`=1, chain unchanged afterwards.
- **Fault injection.** As the basic test, but the model inverts its tail output during the 4th VERIFY cycle → `crc_ok`=0.
- **Stall.** `cfg_valid` low for 5 cycles between the two words → `ccff_shift_en` low for exactly those cycles, `ccff_head` held, and the final chain contents identical to the basic test.
- **No verify.** verify_en=0, CHAIN_LEN=16, words 0x12, 0x34 → 16 shift cycles, `done` one cycle after the last shift, `crc_ok`=1, no VERIFY cycles.
- **Ignored start.** `start` pulsed while `busy` → no effect; exactly one `done` results.
- **Reset mid-operation.** `pReset` asserted in the 5th LOAD cycle → all outputs 0 immediately. A subsequent full load + verify then gives `crc_ok`=1.
